// File: rtl/stv_5838_rom_port_pkg.sv
// Shared STV definitions for the 315-5838 compressed-data read port:
// responder state encoding and address widths.
package stv_5838_rom_port_pkg;

  localparam int ROM_ADDR_W = 23;
  localparam int SDR_ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DEMAND    = 2'd1,
    ST_PREFETCH  = 2'd2,
    ST_PF_DEMAND = 2'd3
  } rom_state_t;

endpackage

// File: rtl/stv_5838_rom_port.sv
// Answers the 315-5838 decompressor's word fetches from cartridge ROM in
// SDRAM.  A one-word prefetch buffer holds the word after the last one
// served, so the chip's sequential stream normally hits in one cycle.
module stv_5838_rom_port
  import stv_5838_rom_port_pkg::*;
#(
  parameter logic [SDR_ADDR_W-1:0] BASE   = 24'h000000,
  parameter int                    DATA_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INV,
  input  logic [ROM_ADDR_W-1:0] MEM_A,
  input  logic                  MEM_RD,
  output logic [DATA_W-1:0]     MEM_DO,
  output logic                  MEM_RDY,
  output logic [SDR_ADDR_W-1:0] SDR_A,
  output logic                  SDR_REQ,
  input  logic [DATA_W-1:0]     SDR_DI,
  input  logic                  SDR_ACK
);

  // Next word address; the ROM space wraps at 2^23.
  function automatic logic [ROM_ADDR_W-1:0] inc_addr(input logic [ROM_ADDR_W-1:0] a);
    return a + {{(ROM_ADDR_W-1){1'b0}}, 1'b1};
  endfunction

  // Place a ROM word address inside the SDRAM window, modulo 2^24.
  function automatic logic [SDR_ADDR_W-1:0] sdr_addr(input logic [ROM_ADDR_W-1:0] a);
    return BASE + {1'b0, a};
  endfunction

  rom_state_t state, state_nx;

  logic [DATA_W-1:0]     buf_data, buf_data_nx;
  logic [ROM_ADDR_W-1:0] buf_tag, buf_tag_nx;
  logic                  buf_v, buf_v_nx;
  logic [ROM_ADDR_W-1:0] pend, pend_nx;
  // Set when an INV lands while a prefetch is in flight: its data is stale.
  logic                  pf_stale, pf_stale_nx;

  logic [DATA_W-1:0]     mem_do_nx;
  logic                  mem_rdy_nx;
  logic [SDR_ADDR_W-1:0] sdr_a_nx;
  logic                  sdr_req_nx;

  logic rd_ok;
  logic hit;
  logic pf_good;
  logic rd_tag_match;
  logic pend_tag_match;

  // Strobes while a fetch is pending are protocol violations and dropped.
  assign rd_ok          = MEM_RD & MEM_RDY;
  // INV in the same cycle as a read makes the buffered word unusable.
  assign hit            = buf_v & ~INV & (buf_tag == MEM_A);
  assign pf_good        = ~pf_stale & ~INV;
  assign rd_tag_match   = (MEM_A == buf_tag);
  assign pend_tag_match = (pend == buf_tag);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decision.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (rd_ok) state_nx = hit ? ST_PREFETCH : ST_DEMAND;
      end
      ST_DEMAND: begin
        if (SDR_ACK) state_nx = ST_PREFETCH;
      end
      ST_PREFETCH: begin
        if (SDR_ACK) begin
          if (rd_ok) state_nx = (rd_tag_match && pf_good) ? ST_PREFETCH : ST_DEMAND;
          else       state_nx = ST_IDLE;
        end else if (rd_ok) begin
          state_nx = ST_PF_DEMAND;
        end
      end
      ST_PF_DEMAND: begin
        if (SDR_ACK) state_nx = (pend_tag_match && pf_good) ? ST_PREFETCH : ST_DEMAND;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Next values of the buffer, the read-port outputs and the SDRAM request.
  always_comb begin
    buf_data_nx = buf_data;
    buf_tag_nx  = buf_tag;
    buf_v_nx    = buf_v & ~INV;
    pend_nx     = pend;
    pf_stale_nx = pf_stale | INV;
    mem_do_nx   = MEM_DO;
    mem_rdy_nx  = MEM_RDY;
    sdr_a_nx    = SDR_A;
    sdr_req_nx  = SDR_REQ;

    case (state)
      ST_IDLE: begin
        if (rd_ok) begin
          if (hit) begin
            mem_do_nx   = buf_data;
            buf_tag_nx  = inc_addr(MEM_A);
            buf_v_nx    = 1'b0;
            pf_stale_nx = INV;
            sdr_a_nx    = sdr_addr(inc_addr(MEM_A));
            sdr_req_nx  = 1'b1;
          end else begin
            mem_rdy_nx = 1'b0;
            pend_nx    = MEM_A;
            sdr_a_nx   = sdr_addr(MEM_A);
            sdr_req_nx = 1'b1;
          end
        end
      end

      ST_DEMAND: begin
        if (SDR_ACK) begin
          mem_do_nx   = SDR_DI;
          mem_rdy_nx  = 1'b1;
          buf_tag_nx  = inc_addr(pend);
          buf_v_nx    = 1'b0;
          pf_stale_nx = INV;
          sdr_a_nx    = sdr_addr(inc_addr(pend));
          sdr_req_nx  = 1'b1;
        end
      end

      ST_PREFETCH: begin
        if (SDR_ACK) begin
          buf_data_nx = SDR_DI;
          buf_v_nx    = pf_good;
          sdr_req_nx  = 1'b0;
          if (rd_ok) begin
            if (rd_tag_match && pf_good) begin
              // The word arriving now is the one being asked for.
              mem_do_nx   = SDR_DI;
              buf_tag_nx  = inc_addr(MEM_A);
              buf_v_nx    = 1'b0;
              pf_stale_nx = 1'b0;
              sdr_a_nx    = sdr_addr(inc_addr(MEM_A));
              sdr_req_nx  = 1'b1;
            end else begin
              mem_rdy_nx = 1'b0;
              pend_nx    = MEM_A;
              sdr_a_nx   = sdr_addr(MEM_A);
              sdr_req_nx = 1'b1;
            end
          end
        end else if (rd_ok) begin
          // Keep the prefetch running; decide on its ack whether it is useful.
          mem_rdy_nx = 1'b0;
          pend_nx    = MEM_A;
        end
      end

      ST_PF_DEMAND: begin
        if (SDR_ACK) begin
          if (pend_tag_match && pf_good) begin
            mem_do_nx   = SDR_DI;
            mem_rdy_nx  = 1'b1;
            buf_tag_nx  = inc_addr(pend);
            buf_v_nx    = 1'b0;
            pf_stale_nx = INV;
            sdr_a_nx    = sdr_addr(inc_addr(pend));
            sdr_req_nx  = 1'b1;
          end else begin
            sdr_a_nx   = sdr_addr(pend);
            sdr_req_nx = 1'b1;
          end
        end
      end

      default: ;
    endcase
  end

  // Control and port registers; reset abandons any request in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      buf_v    <= 1'b0;
      pf_stale <= 1'b0;
      MEM_DO   <= '0;
      MEM_RDY  <= 1'b1;
      SDR_A    <= '0;
      SDR_REQ  <= 1'b0;
    end else begin
      buf_v    <= buf_v_nx;
      pf_stale <= pf_stale_nx;
      MEM_DO   <= mem_do_nx;
      MEM_RDY  <= mem_rdy_nx;
      SDR_A    <= sdr_a_nx;
      SDR_REQ  <= sdr_req_nx;
    end
  end

  // Buffer contents and pending address carry no reset; buf_v qualifies them.
  always_ff @(posedge CLK) begin
    buf_data <= buf_data_nx;
    buf_tag  <= buf_tag_nx;
    pend     <= pend_nx;
  end

endmodule
